// File: rtl/counter_offset_if.sv
// counter_offset_if: control and result bundle for counter_offset_mod.
//
// master modport: the sequencer. It drives the load/count controls and the
//   signed output offset, and it observes the results.
// slave modport: the counter. It receives the controls and drives count,
//   value, ovf, unf, tc and wrap.
//
// Signals (W = $clog2(MOD)):
//   load_max  1      load count with MOD-1
//   load      1      load count with load_val (clamped to MOD-1)
//   load_val  W      preload value
//   en        1      count enable
//   dir       1      0 = up, 1 = down
//   offset    OFF_W  signed two's-complement output offset
//   count     W      stored count
//   value     W      (count + offset) mod MOD
//   ovf       1      count + offset >= MOD
//   unf       1      count + offset < 0
//   tc        1      terminal count in the current direction
//   wrap      1      registered one-cycle pulse after a wrapping count edge
interface counter_offset_if #(
    parameter int MOD   = 24,
    parameter int OFF_W = 3
);
    localparam int W = $clog2(MOD);

    logic             load_max;
    logic             load;
    logic [W-1:0]     load_val;
    logic             en;
    logic             dir;
    logic [OFF_W-1:0] offset;
    logic [W-1:0]     count;
    logic [W-1:0]     value;
    logic             ovf;
    logic             unf;
    logic             tc;
    logic             wrap;

    modport master (
        output load_max, load, load_val, en, dir, offset,
        input  count, value, ovf, unf, tc, wrap
    );

    modport slave (
        input  load_max, load, load_val, en, dir, offset,
        output count, value, ovf, unf, tc, wrap
    );
endinterface

// File: rtl/counter_offset_mod.sv
// counter_offset_mod: modulo-MOD up/down counter with a signed, runtime
// programmable output offset. The offset only shapes the combinational
// output value; the stored count is never touched by it.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (count = 0, wrap = 0)
//   bus  counter_offset_if.slave: load_max/load/load_val/en/dir/offset in,
//        count/value/ovf/unf/tc/wrap out
//
// Update priority per edge: rst > load_max > load > en > hold.
module counter_offset_mod #(
    parameter int MOD   = 24,
    parameter int OFF_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    counter_offset_if.slave bus
);
    localparam int W   = $clog2(MOD);
    // Two guard bits above the wider operand keep the sum exact and signed.
    localparam int S_W = ((W > OFF_W) ? W : OFF_W) + 2;

    localparam logic [W-1:0]          CNT_MAX = W'(MOD - 1);
    localparam logic signed [S_W-1:0] MOD_S   = S_W'(MOD);

    generate
        if (MOD < 2) begin : g_bad_mod
            $error("counter_offset_mod: MOD must be at least 2");
        end
        if ((1 << (OFF_W - 1)) > MOD) begin : g_bad_off
            $error("counter_offset_mod: 2**(OFF_W-1) must not exceed MOD");
        end
    endgenerate

    // Adds the offset to the count and folds the result back into 0..MOD-1.
    // |offset| <= MOD, so a single add or subtract of MOD is always enough.
    // Returns {ovf, unf, value}.
    function automatic logic [W+1:0] fold_offset(
        input logic [W-1:0]              cnt,
        input logic signed [OFF_W-1:0]   off
    );
        logic signed [S_W-1:0] s;
        s = $signed({{(S_W - W){1'b0}}, cnt})
          + $signed({{(S_W - OFF_W){off[OFF_W-1]}}, off});
        if (s < 0) begin
            return {1'b0, 1'b1, W'(s + MOD_S)};
        end else if (s >= MOD_S) begin
            return {1'b1, 1'b0, W'(s - MOD_S)};
        end else begin
            return {2'b00, W'(s)};
        end
    endfunction

    logic [W-1:0]            count_r;
    logic                    wrap_r;
    logic                    at_max;
    logic                    at_zero;
    logic signed [OFF_W-1:0] offset_s;
    logic [W+1:0]            folded;

    assign at_max   = (count_r == CNT_MAX);
    assign at_zero  = (count_r == '0);
    assign offset_s = $signed(bus.offset);
    assign folded   = fold_offset(count_r, offset_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else if (bus.load_max) begin
            count_r <= CNT_MAX;
            wrap_r  <= 1'b0;
        end else if (bus.load) begin
            // Out-of-range preloads saturate so count stays inside 0..MOD-1.
            count_r <= (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
            wrap_r  <= 1'b0;
        end else if (bus.en) begin
            if (!bus.dir) begin
                count_r <= at_max ? '0 : count_r + 1'b1;
                wrap_r  <= at_max;
            end else begin
                count_r <= at_zero ? CNT_MAX : count_r - 1'b1;
                wrap_r  <= at_zero;
            end
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    assign bus.count = count_r;
    assign bus.wrap  = wrap_r;
    assign bus.ovf   = folded[W+1];
    assign bus.unf   = folded[W];
    assign bus.value = folded[W-1:0];
    // Announces the wrap one cycle ahead of the edge that performs it.
    assign bus.tc    = bus.en & (bus.dir ? at_zero : at_max);
endmodule

// File: tb/tb_counter_offset_mod.sv
// tb_counter_offset_mod: directed scoreboard bench for counter_offset_mod.
// Two instances: MOD=24/OFF_W=3 and the MOD=2/OFF_W=2 corner.
// Each stimulus cycle drives inputs and queues the hand-computed outputs
// expected for that cycle; a negedge monitor pops and compares.
module tb_counter_offset_mod;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    counter_offset_if #(.MOD(24), .OFF_W(3)) bus_a ();
    counter_offset_if #(.MOD(2),  .OFF_W(2)) bus_b ();

    counter_offset_mod #(.MOD(24), .OFF_W(3)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    counter_offset_mod #(.MOD(2), .OFF_W(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    typedef struct {
        bit b;
        int c;
        int v;
        bit o;
        bit u;
        bit t;
        bit w;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input string fld, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (!e.b) begin
                check(t, "count", int'(bus_a.count), e.c);
                check(t, "value", int'(bus_a.value), e.v);
                check(t, "ovf",   int'(bus_a.ovf),   int'(e.o));
                check(t, "unf",   int'(bus_a.unf),   int'(e.u));
                check(t, "tc",    int'(bus_a.tc),    int'(e.t));
                check(t, "wrap",  int'(bus_a.wrap),  int'(e.w));
            end else begin
                check(t, "count", int'(bus_b.count), e.c);
                check(t, "value", int'(bus_b.value), e.v);
                check(t, "ovf",   int'(bus_b.ovf),   int'(e.o));
                check(t, "unf",   int'(bus_b.unf),   int'(e.u));
                check(t, "tc",    int'(bus_b.tc),    int'(e.t));
                check(t, "wrap",  int'(bus_b.wrap),  int'(e.w));
            end
        end
    end

    task automatic push(input string tag, input bit b, input int ec, input int ev,
                        input bit eo, input bit eu, input bit et, input bit ew);
        exp_t e;
        e.b = b; e.c = ec; e.v = ev; e.o = eo; e.u = eu; e.t = et; e.w = ew;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One cycle on instance A: drive inputs, queue expected outputs for this
    // cycle (count/wrap from the previous edge), then cross the next edge.
    task automatic cyc_a(input string tag, input bit r, input bit lmax, input bit ld,
                         input int lv, input bit en, input bit dir, input int off,
                         input int ec, input int ev, input bit eo, input bit eu,
                         input bit et, input bit ew);
        rst_a          = r;
        bus_a.load_max = lmax;
        bus_a.load     = ld;
        bus_a.load_val = 5'(lv);
        bus_a.en       = en;
        bus_a.dir      = dir;
        bus_a.offset   = 3'(off);
        push(tag, 1'b0, ec, ev, eo, eu, et, ew);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input string tag, input bit r, input bit lmax, input bit ld,
                         input int lv, input bit en, input bit dir, input int off,
                         input int ec, input int ev, input bit eo, input bit eu,
                         input bit et, input bit ew);
        rst_b          = r;
        bus_b.load_max = lmax;
        bus_b.load     = ld;
        bus_b.load_val = 1'(lv);
        bus_b.en       = en;
        bus_b.dir      = dir;
        bus_b.offset   = 2'(off);
        push(tag, 1'b1, ec, ev, eo, eu, et, ew);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.load_max = 1'b0; bus_a.load = 1'b0; bus_a.load_val = '0;
        bus_a.en = 1'b0; bus_a.dir = 1'b0; bus_a.offset = '0;
        bus_b.load_max = 1'b0; bus_b.load = 1'b0; bus_b.load_val = '0;
        bus_b.en = 1'b0; bus_b.dir = 1'b0; bus_b.offset = '0;
        @(posedge clk);
        #1;

        //    tag          r lm ld lv en dr off   cnt val o u t w
        cyc_a("reset",     1, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,0);
        for (int i = 0; i < 5; i++)
            cyc_a("hold",  0, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,0);

        for (int i = 0; i < 24; i++)
            cyc_a("up",    0, 0, 0, 0, 1, 0,  0,   i,  i, 0,0, (i == 23), 0);
        cyc_a("up_wrap",   0, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,1);
        cyc_a("up_end",    0, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,0);

        cyc_a("dn_load",   0, 0, 1, 1, 0, 0,  0,   0,  0, 0,0,0,0);
        cyc_a("dn1",       0, 0, 0, 0, 1, 1,  0,   1,  1, 0,0,0,0);
        cyc_a("dn0",       0, 0, 0, 0, 1, 1,  0,   0,  0, 0,0,1,0);
        cyc_a("dn_rev",    0, 0, 0, 0, 1, 0,  0,  23, 23, 0,0,1,1);
        cyc_a("rev_wrap",  0, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,1);

        cyc_a("off_load",  0, 0, 1,22, 0, 0,  0,   0,  0, 0,0,0,0);
        cyc_a("off_p3",    0, 0, 0, 0, 0, 0,  3,  22,  1, 1,0,0,0);
        cyc_a("off_m4_22", 0, 0, 1, 1, 0, 0, -4,  22, 18, 0,0,0,0);
        cyc_a("off_m4_1",  0, 0, 1,10, 0, 0, -4,   1, 21, 0,1,0,0);
        cyc_a("off_m1",    0, 0, 0, 0, 0, 0, -1,  10,  9, 0,0,0,0);
        cyc_a("off_p3_10", 0, 0, 0, 0, 0, 0,  3,  10, 13, 0,0,0,0);

        cyc_a("clamp30",   0, 0, 1,30, 1, 0,  0,  10, 10, 0,0,0,0);
        cyc_a("rst_lmax",  1, 1, 0, 0, 0, 0,  0,  23, 23, 0,0,0,0);
        cyc_a("lmax",      0, 1, 0, 0, 0, 0,  0,   0,  0, 0,0,0,0);
        cyc_a("rst_en",    1, 0, 0, 0, 1, 0, -1,  23, 22, 0,0,1,0);
        cyc_a("rst_after", 0, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,0);
        cyc_a("clamp24",   0, 0, 1,24, 0, 0,  1,   0,  1, 0,0,0,0);
        cyc_a("max_p1",    0, 0, 0, 0, 0, 0,  1,  23,  0, 1,0,0,0);
        cyc_a("max_hold",  0, 0, 0, 0, 0, 1,  0,  23, 23, 0,0,0,0);

        cyc_b("b_reset",   1, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,0);
        cyc_b("b_up0",     0, 0, 0, 0, 1, 0,  0,   0,  0, 0,0,0,0);
        cyc_b("b_up1",     0, 0, 0, 0, 1, 0,  0,   1,  1, 0,0,1,0);
        cyc_b("b_up2",     0, 0, 0, 0, 1, 0,  0,   0,  0, 0,0,0,1);
        cyc_b("b_up3",     0, 0, 0, 0, 1, 0,  0,   1,  1, 0,0,1,0);
        cyc_b("b_idle",    0, 0, 0, 0, 0, 0,  0,   0,  0, 0,0,0,1);
        cyc_b("b_load",    0, 0, 1, 1, 0, 0,  0,   0,  0, 0,0,0,0);
        cyc_b("b_off_m2",  0, 0, 0, 0, 0, 0, -2,   1,  1, 0,1,0,0);
        cyc_b("b_off_p1",  0, 0, 0, 0, 0, 0,  1,   1,  0, 1,0,0,0);
        cyc_b("b_dn0",     0, 0, 0, 0, 1, 1,  0,   1,  1, 0,0,0,0);
        cyc_b("b_dn1",     0, 0, 0, 0, 1, 1,  0,   0,  0, 0,0,1,0);
        cyc_b("b_dn_end",  0, 0, 0, 0, 0, 0,  0,   1,  1, 0,0,0,1);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", "queue_size", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_offset_mod.md
# counter_offset_mod

Parametrised modulo-MOD up/down counter with a signed, runtime-programmable output offset. The offset is applied combinationally to the output; the stored count is never modified by it. It replaces fixed 2-bit-coded offset counters in the sensor-controller sequencing logic (row/column/phase indexing) wherever arbitrary signed offsets, bidirectional counting, arbitrary preload and wrap reporting are needed.

## Interface

Parameters:
- MOD, 24: counter modulus; legal range MOD >= 2. W = $clog2(MOD).
- OFF_W, 3: width of the signed two's-complement offset; legal only if 2^(OFF_W-1) <= MOD (elaboration-time check, $error otherwise).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- load_max  in  1  load count <= MOD-1.
- load  in  1  load count <= load_val.
- load_val  in  W  preload value.
- en  in  1  count enable.
- dir  in  1  0 = count up, 1 = count down.
- offset  in  OFF_W  signed output offset.
- count  out  W  stored count.
- value  out  W  (count + offset) mod MOD.
- ovf  out  1  count + offset >= MOD.
- unf  out  1  count + offset < 0.
- tc  out  1  terminal count in current direction.
- wrap  out  1  registered one-cycle wrap pulse.

## Operation

- Update priority at each edge: rst > load_max > load > en > hold.
- rst: count <= 0, wrap <= 0.
- load_max: count <= MOD-1. load: count <= load_val if load_val < MOD, else count <= MOD-1 (saturating clamp). Neither load asserts wrap.
- en, dir=0: count <= (count == MOD-1) ? 0 : count+1. en, dir=1: count <= (count == 0) ? MOD-1 : count-1.
- wrap <= 1 only when the edge's selected action is en and the count wrapped (MOD-1 -> 0 up, 0 -> MOD-1 down); otherwise wrap <= 0.
- tc = en & ((dir==0 & count==MOD-1) | (dir==1 & count==0)); combinational, precedes the wrapping edge.
- Offset arithmetic: s = zero-extended count + sign-extended offset, computed at signed width max(W, OFF_W)+2 (no truncation).
  - s < 0: unf=1, ovf=0, value = s + MOD.
  - s >= MOD: ovf=1, unf=0, value = s - MOD.
  - else: ovf=unf=0, value = s.
  - The parameter check bounds |offset| by MOD, so one correction always suffices.
- ovf and unf are never both 1. offset = 0 gives value == count, ovf = unf = 0.
- MOD not a power of two: count never leaves 0..MOD-1 by counting or loading.

## Timing

- Reset values: count=0, wrap=0. With offset=0, en=0: value=0, ovf=unf=tc=0.
- count and wrap are registered, updating one edge after the qualifying inputs.
- value, ovf, unf and tc are combinational from count, offset, en and dir, valid in the same cycle. No internal registering, zero latency.
- offset may change every cycle and has no effect on stored state.
- rst asserted mid-count overrides simultaneous load/en. The following cycle shows count=0, wrap=0.
- load and en together: load wins, wrap=0.
- Direction reversal takes effect on the next enabled edge, with no dead cycle.

## Test plan

MOD=24, OFF_W=3 unless noted.

- Reset/hold: rst 1 cycle, then en=0 for 5 cycles -> count=0, wrap=0 throughout, value=0 with offset=0.
- Up wrap: en=1, dir=0 from 0 for 24 edges. tc=1 while count=23. -> count 23->0, wrap=1 for exactly the cycle after that edge, and only then.
- Down wrap and reversal: load_val=1, then dir=1 for 3 edges -> count 1,0,23, wrap pulse after the 0->23 edge. Then dir=0 -> 0.
- Offset sweep: count=22, offset=+3 -> value=1, ovf=1. count=1, offset=-4 -> value=21, unf=1. count=10, offset=-1 -> value=9, flags 0. count unchanged in all three.
- Load priority/clamp: load=1, load_val=30, en=1 -> count=23, wrap=0. rst=1 with load_max=1 -> count=0. load_max alone -> count=23.
- Parameter corner: MOD=2, OFF_W=2. Count up toggles 0,1,0, with wrap after each 1->0 edge. offset=-2, count=1 -> value=1, unf=1.
